// File: rtl/mac_acc_o.sv
// mac_acc_o: multiply-accumulate stage for one output neuron.
// Takes the term index stream from the output-neuron address counter, pairs
// each in-range index with the weight/hidden words returned by the external
// synchronous-read RAMs one cycle later, accumulates the signed products plus
// the bias, and emits one saturated result per run.
//
// Handshake: sel is meaningful only while sel_rdy is high; sel_rdy stays high
// for the whole counter run and its fall ends the run. There is no
// backpressure. out_rdy is a single-cycle strobe with no ready; out_data is
// valid in that cycle and holds until the next result or reset.
module mac_acc_o #(
  parameter int DW      = 16,
  parameter int FRAC    = 8,
  parameter int N_TERMS = 8,
  parameter int AW      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] sel,
  input  logic          sel_rdy,
  input  logic [DW-1:0] w_data,
  input  logic [DW-1:0] hid_data,
  input  logic [DW-1:0] b_data,
  output logic [DW-1:0] out_data,
  output logic          out_rdy,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  localparam int ACC_W = 2*DW + 4;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_TERMS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  // Stage-1 registers line the index up with the RAM read data.
  logic          v1;
  logic          run1;
  logic [AW-1:0] i1;
  logic [AW-1:0] last_i;

  logic signed [ACC_W-1:0] acc;
  logic signed [2*DW-1:0]  w_ext, h_ext, prod;
  logic signed [ACC_W-1:0] prod_ext, bias_ext, acc_shr;
  logic [DW-1:0]           sat_val;

  logic term_first, term_add, acc_clr;

  // Both operands sign-extended to the product width so the low 2*DW bits
  // of the multiply are the exact signed product.
  assign w_ext    = {{DW{w_data[DW-1]}}, w_data};
  assign h_ext    = {{DW{hid_data[DW-1]}}, hid_data};
  assign prod     = w_ext * h_ext;
  assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  assign bias_ext = {{(ACC_W-DW){b_data[DW-1]}}, b_data} << FRAC;
  assign acc_shr  = acc >>> FRAC;

  assign busy      = (state == ACC);
  assign dbg_state = state;

  // Stage 1: register validity, index and run flag for the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1   <= 1'b0;
      run1 <= 1'b0;
      i1   <= '0;
    end else begin
      v1   <= sel_rdy && (int'(sel) < N_TERMS);
      run1 <= sel_rdy;
      i1   <= sel;
    end
  end

  // Next-state and accumulator control.
  always_comb begin
    state_next = state;
    term_first = 1'b0;
    term_add   = 1'b0;
    acc_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (v1 && (i1 == '0)) begin
          term_first = 1'b1;
          state_next = (i1 == LAST_IDX) ? FIN : ACC;
        end
      end
      ACC: begin
        if (!run1) begin
          acc_clr    = 1'b1;
          state_next = IDLE;
        end else if (v1) begin
          if (i1 == last_i + AW'(1)) begin
            term_add = 1'b1;
            if (i1 == LAST_IDX) state_next = FIN;
          end else begin
            acc_clr    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      FIN:     state_next = DONE;
      DONE:    if (!run1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Accumulator and the index of the last accepted term.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      last_i <= '0;
    end else if (acc_clr) begin
      acc    <= '0;
    end else if (term_first) begin
      acc    <= bias_ext + prod_ext;
      last_i <= i1;
    end else if (term_add) begin
      acc    <= acc + prod_ext;
      last_i <= i1;
    end
  end

  // Rescale the accumulator and clamp it to the DW-bit signed range.
  always_comb begin
    sat_val = acc_shr[DW-1:0];
    if (acc_shr > SAT_MAX)      sat_val = {1'b0, {(DW-1){1'b1}}};
    else if (acc_shr < SAT_MIN) sat_val = {1'b1, {(DW-1){1'b0}}};
  end

  // Result register: load in FIN, strobe out_rdy the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data <= '0;
      out_rdy  <= 1'b0;
    end else begin
      out_rdy <= (state == FIN);
      if (state == FIN) out_data <= sat_val;
    end
  end

endmodule
